// File: rtl/bus_xcvr_pkg.sv
// Shared types and constants for the octal bus transceiver sequencer.
// Contents: FSM state encoding, transceiver DIR encodings, counter width.
// No logic; imported by bus_xcvr_ctrl and rr_arbiter2.
package bus_xcvr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Transceiver DIR pin encodings.
  localparam logic DIR_A2B = 1'b1;  // write: A side drives B
  localparam logic DIR_B2A = 1'b0;  // read:  B side drives A

  // State counters are reloaded on every state entry; 4 bits covers WAIT_CYC<=15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/bus_xcvr_ctrl_rr_arbiter2.sv
// Two-input grant logic with last-grant pointer (combinational, zero latency).
// Ports: req0/req1 requests, last_sel = master granted last; gnt_vld/gnt_sel grant.
// No backpressure; optional macro BUS_XCVR_FIXED_PRIO_EN makes master 0 always win.
module rr_arbiter2 import bus_xcvr_pkg::*; (
  input  logic req0,
  input  logic req1,
  input  logic last_sel,
  output logic gnt_vld,
  output logic gnt_sel
);

  always_comb begin
    gnt_vld = req0 | req1;
`ifdef BUS_XCVR_FIXED_PRIO_EN
    // Master 0 wins every tie; master 1 can starve.
    gnt_sel = ~req0;
`else
    // On a tie, hand the bus to the master that did not have it last.
    if (req0 && req1) begin
      gnt_sel = ~last_sel;
    end else begin
      gnt_sel = req1;
    end
`endif
  end

`ifdef BUS_XCVR_FIXED_PRIO_EN
  logic unused_last_sel;
  assign unused_last_sel = last_sel;
`endif

endmodule

// File: rtl/bus_xcvr_ctrl.sv
// Bus-cycle sequencer for an octal transceiver shared by two masters.
// Latency: req seen in IDLE at N -> OE high N+1(+TURN_CYC)..; ack one cycle after the last OE cycle.
// Backpressure: masters hold req until their one-cycle ack; the non-owner simply waits.
// Ports: m0_*/m1_* requester interfaces; bus_sel/bus_dir/bus_oe/bus_dout/bus_din transceiver side.
// Optional macro BUS_XCVR_FIXED_PRIO_EN (in rr_arbiter2): fixed m0 priority instead of round-robin.
module bus_xcvr_ctrl import bus_xcvr_pkg::*; #(
  parameter int DW       = 8,
  parameter int WAIT_CYC = 2,
  parameter int TURN_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          bus_sel,
  output logic          bus_dir,
  output logic          bus_oe,
  output logic [DW-1:0] bus_dout,
  input  logic [DW-1:0] bus_din
);

  // Counters hold "cycles remaining minus one" so the last cycle is cnt==0.
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [DW-1:0]    wdata_q;
  logic             last_dir;
  logic             rr_last;

  logic             gnt_vld;
  logic             gnt_sel;
  logic             gnt_we;
  logic [DW-1:0]    gnt_wdata;

  rr_arbiter2 u_arb (
    .req0     (m0_req),
    .req1     (m1_req),
    .last_sel (rr_last),
    .gnt_vld  (gnt_vld),
    .gnt_sel  (gnt_sel)
  );

  assign gnt_we    = gnt_sel ? m1_we    : m0_we;
  assign gnt_wdata = gnt_sel ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      last_dir <= DIR_B2A;
      rr_last  <= 1'b1;  // "last granted m1" so the first tie goes to m0
      bus_sel  <= 1'b0;
      bus_dir  <= DIR_B2A;
      bus_oe   <= 1'b0;
      bus_dout <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            bus_sel <= gnt_sel;
            we_q    <= gnt_we;
            wdata_q <= gnt_wdata;
            // DIR moves here, while OE is still low; TURN then holds OE low.
            bus_dir <= gnt_we;
            if ((gnt_we != last_dir) && (TURN_CYC > 0)) begin
              state <= TURN;
              cnt   <= TURN_LD;
            end else begin
              state    <= ACCESS;
              cnt      <= WAIT_LD;
              bus_oe   <= 1'b1;
              bus_dout <= (gnt_we == DIR_A2B) ? gnt_wdata : '0;
            end
          end
        end
        TURN: begin
          if (cnt == '0) begin
            state    <= ACCESS;
            cnt      <= WAIT_LD;
            bus_oe   <= 1'b1;
            bus_dout <= (we_q == DIR_A2B) ? wdata_q : '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state    <= DONE;
            bus_oe   <= 1'b0;
            bus_dout <= '0;
            if (bus_sel) m1_ack <= 1'b1;
            else         m0_ack <= 1'b1;
            // Read data is taken on the final OE cycle, when the B side has settled.
            if (!we_q) begin
              if (bus_sel) m1_rdata <= bus_din;
              else         m0_rdata <= bus_din;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          last_dir <= we_q;
          rr_last  <= bus_sel;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xcvr_ctrl.sv
// Self-checking bench for bus_xcvr_ctrl: per-cycle timeline model plus directed pins.
// Latency: n/a (bench). Backpressure: bench masters hold req until ack.
// Honours BUS_XCVR_FIXED_PRIO_EN for the expected grant order.
module tb_bus_xcvr_ctrl;

  localparam int DW       = 8;
  localparam int WAIT_CYC = 2;
  localparam int TURN_CYC = 1;
  localparam int LOGN     = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [DW-1:0] m0_wdata = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic          bus_sel, bus_dir, bus_oe;
  logic [DW-1:0] bus_dout;
  logic [DW-1:0] bus_din = '0;

  bus_xcvr_ctrl #(.DW(DW), .WAIT_CYC(WAIT_CYC), .TURN_CYC(TURN_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .bus_sel(bus_sel), .bus_dir(bus_dir), .bus_oe(bus_oe), .bus_dout(bus_dout), .bus_din(bus_din)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pending transactions per master: {we, wdata}.
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  logic        drop0 = 1'b0;

  // Expected outputs, one entry per future cycle of a granted transaction.
  typedef struct packed {
    logic          oe;
    logic          dir;
    logic          sel;
    logic [DW-1:0] dout;
    logic          ack;
    logic          fin_rd;
  } ent_t;
  ent_t sched[$];

  logic          md_last_dir, md_last_sel, md_sel;
  logic [DW-1:0] md_rd0, md_rd1;
  logic          prev_oe, prev_dir;
  int            ack0_cnt = 0;
  logic          ack_order[$];

  logic          lg_oe[LOGN], lg_dir[LOGN], lg_ack0[LOGN], lg_ack1[LOGN];
  logic [DW-1:0] lg_dout[LOGN], lg_rd0[LOGN], lg_rd1[LOGN];

  task automatic model_reset();
    sched.delete();
    md_last_dir = 1'b0;
    md_last_sel = 1'b1;
    md_sel      = 1'b0;
    md_rd0      = '0;
    md_rd1      = '0;
    prev_oe     = 1'b0;
    prev_dir    = 1'b0;
  endtask

  task automatic drive_masters();
    if (m0_ack) void'(q0.pop_front());
    if (m1_ack) void'(q1.pop_front());
    if (q0.size() > 0 && !m0_ack && !drop0) begin
      m0_req = 1'b1; {m0_we, m0_wdata} = q0[0];
    end else m0_req = 1'b0;
    if (q1.size() > 0 && !m1_ack) begin
      m1_req = 1'b1; {m1_we, m1_wdata} = q1[0];
    end else m1_req = 1'b0;
  endtask

  task automatic step();
    ent_t e;
    logic idle_m, s, we;
    logic [DW-1:0] wd;
    idle_m = (sched.size() == 0);
    if (idle_m) e = '{oe: 1'b0, dir: md_last_dir, sel: md_sel, dout: '0, ack: 1'b0, fin_rd: 1'b0};
    else        e = sched[0];
    chk("bus_oe", bus_oe, e.oe);
    chk("bus_dir", bus_dir, e.dir);
    chk("bus_sel", bus_sel, e.sel);
    if (e.oe) chk("bus_dout", bus_dout, e.dout);
    chk("m0_ack", m0_ack, e.ack && !e.sel);
    chk("m1_ack", m1_ack, e.ack && e.sel);
    chk("m0_rdata", m0_rdata, md_rd0);
    chk("m1_rdata", m1_rdata, md_rd1);
    if (bus_dir !== prev_dir) chk("dir_change_oe_low", {prev_oe, bus_oe}, 2'b00);
    prev_oe = bus_oe; prev_dir = bus_dir;
    if (cyc < LOGN) begin
      lg_oe[cyc] = bus_oe; lg_dir[cyc] = bus_dir; lg_dout[cyc] = bus_dout;
      lg_ack0[cyc] = m0_ack; lg_ack1[cyc] = m1_ack;
      lg_rd0[cyc] = m0_rdata; lg_rd1[cyc] = m1_rdata;
    end
    if (m0_ack) begin ack0_cnt++; ack_order.push_back(1'b0); end
    if (m1_ack) ack_order.push_back(1'b1);

    drive_masters();

    if (!idle_m) begin
      if (e.fin_rd) begin
        if (e.sel) md_rd1 = bus_din; else md_rd0 = bus_din;
      end
      if (e.ack) begin md_last_dir = e.dir; md_last_sel = e.sel; end
      void'(sched.pop_front());
    end else if (m0_req || m1_req) begin
`ifdef BUS_XCVR_FIXED_PRIO_EN
      s = !m0_req;
`else
      s = (m0_req && m1_req) ? !md_last_sel : m1_req;
`endif
      we = s ? m1_we : m0_we;
      wd = s ? m1_wdata : m0_wdata;
      md_sel = s;
      if (we != md_last_dir)
        for (int i = 0; i < TURN_CYC; i++)
          sched.push_back('{oe: 1'b0, dir: we, sel: s, dout: '0, ack: 1'b0, fin_rd: 1'b0});
      for (int i = 0; i < WAIT_CYC; i++)
        sched.push_back('{oe: 1'b1, dir: we, sel: s, dout: (we ? wd : '0), ack: 1'b0,
                          fin_rd: (!we && i == WAIT_CYC - 1)});
      sched.push_back('{oe: 1'b0, dir: we, sel: s, dout: '0, ack: 1'b1, fin_rd: 1'b0});
    end
  endtask

  // Compare process: outputs sampled 2 time units after each rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (rst_n) step();
    end
  end

  task automatic wait_done(input int max, input string nm);
    int i;
    for (i = 0; i < max; i++) begin
      @(posedge clk); #3;
      if (q0.size() == 0 && q1.size() == 0 && sched.size() == 0) break;
    end
    if (i == max) chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_oe(input int max, input string nm);
    int i;
    for (i = 0; i < max; i++) begin
      @(posedge clk); #3;
      if (bus_oe) break;
    end
    if (i == max) chk({nm, "_oe_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0;
    logic [8:0] oe_pat;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_oe", bus_oe, 0);    chk("rst_dir", bus_dir, 0);  chk("rst_sel", bus_sel, 0);
    chk("rst_dout", bus_dout, 0); chk("rst_ack", {m0_ack, m1_ack}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: m0 write A5 with turnaround from the reset read direction.
    @(posedge clk); #3;
    q0.push_back({1'b1, 8'hA5}); n = cyc + 1;
    wait_done(40, "t1");
    chk("t1_turn", {lg_oe[n+1], lg_dir[n+1]}, 2'b01);
    chk("t1_acc1", {lg_oe[n+2], lg_dir[n+2], lg_dout[n+2]}, {2'b11, 8'hA5});
    chk("t1_acc2", {lg_oe[n+3], lg_dir[n+3], lg_dout[n+3]}, {2'b11, 8'hA5});
    chk("t1_ack", {lg_ack0[n+3], lg_ack0[n+4], lg_oe[n+4]}, 3'b010);

    // 2: m0 read (takes 0x11), then m1 read of 0x3C with no turnaround.
    bus_din = 8'h11; q0.push_back({1'b0, 8'h00});
    wait_done(40, "t2a");
    bus_din = 8'h3C; q1.push_back({1'b0, 8'h00}); n = cyc + 1;
    wait_done(40, "t2b");
    chk("t2_noturn", {lg_oe[n+1], lg_dir[n+1], lg_oe[n+2]}, 3'b101);
    chk("t2_ack1", lg_ack1[n+3], 1'b1);
    chk("t2_rd1", lg_rd1[n+3], 8'h3C);
    chk("t2_rd0", lg_rd0[n+3], 8'h11);

    // 3: both masters request writes continuously.
    ack_order.delete();
    q0.push_back({1'b1, 8'h01}); q0.push_back({1'b1, 8'h02});
    q1.push_back({1'b1, 8'h81}); q1.push_back({1'b1, 8'h82});
    wait_done(80, "t3");
    chk("t3_nacks", ack_order.size(), 4);
    if (ack_order.size() == 4) begin
`ifdef BUS_XCVR_FIXED_PRIO_EN
      chk("t3_order", {ack_order[0], ack_order[1], ack_order[2], ack_order[3]}, 4'b0011);
`else
      chk("t3_order", {ack_order[0], ack_order[1], ack_order[2], ack_order[3]}, 4'b0101);
`endif
    end

    // 4: m0 read then m1 write; OE pattern across both accesses.
    bus_din = 8'h77;
    q0.push_back({1'b0, 8'h00}); q1.push_back({1'b1, 8'hC3}); n = cyc + 1;
    wait_done(60, "t4");
    for (int k = 0; k < 9; k++) oe_pat[8-k] = lg_oe[n+1+k];
    chk("t4_oe_pattern", oe_pat, 9'b0_1100_0110);
    chk("t4_ack1", lg_ack1[n+9], 1'b1);

    // 5: reset during m0's ACCESS while m1 waits.
    q0.push_back({1'b0, 8'h00}); q1.push_back({1'b1, 8'h5C});
    wait_oe(20, "t5");
    rst_n = 1'b0;
    #1;
    chk("t5_async_oe", bus_oe, 0);
    chk("t5_async_ack", {m0_ack, m1_ack}, 0);
    chk("t5_async_rd0", m0_rdata, 0);
    model_reset(); q0.delete(); m0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; n = cyc + 1;
    wait_done(40, "t5");
    chk("t5_fresh_turn", {lg_oe[n+1], lg_dir[n+1]}, 2'b01);
    chk("t5_fresh_acc", {lg_oe[n+2], lg_dout[n+2]}, {1'b1, 8'h5C});
    chk("t5_fresh_ack", lg_ack1[n+4], 1'b1);

    // 6: m0 drops req mid-access; still exactly one ack.
    a0 = ack0_cnt;
    q0.push_back({1'b1, 8'h5A});
    wait_oe(20, "t6");
    drop0 = 1'b1;
    wait_done(40, "t6");
    repeat (6) @(posedge clk);
    #3;
    chk("t6_one_ack", ack0_cnt - a0, 1);
    drop0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
